// File: rtl/cart_loader.sv
// cart_loader: byte-stream loader for the 32 KB cartridge BRAM.
// Frame format: SYNC_BYTE, len[15:8], len[7:0], then len data bytes
// (plus one trailing checksum byte when CART_LOADER_CHECKSUM_EN is defined).
// Each data byte is written to the BRAM one cycle after it is received.
// cpu_hold keeps the GBC core in reset until a complete, valid image is in place.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, so every strobe is consumed and one strobe per cycle is
// sustained. wea is a single-cycle write strobe qualifying addra/dina.
//
// Optional feature macro: CART_LOADER_CHECKSUM_EN (adds the CHECK state and
// the 8-bit mod-256 sum accumulator).
module cart_loader #(
  parameter int          MAX_BYTES      = 32768,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wea,
  output logic [14:0] addra,
  output logic [7:0]  dina,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold,
  output logic [2:0]  dbg_state
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_LEN  = 17'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef CART_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t         state_q;
  logic [15:0]    len_q;
  logic [14:0]    cnt_q;
  logic [TW-1:0]  tmo_q;
  logic           wea_q;
  logic [14:0]    addra_q;
  logic [7:0]     dina_q;
  logic           busy_q;
  logic           done_q;
  logic           error_q;
  logic           hold_q;
`ifdef CART_LOADER_CHECKSUM_EN
  logic [7:0]     sum_q;
  logic [7:0]     sum_d;
`endif

  logic [15:0]    len_d;
  logic           len_bad;
  logic           last_byte;
  logic           in_frame;
  logic           tmo_hit;

  // Length as it will be once the low byte is latched, and its validity.
  assign len_d   = {len_q[15:8], rx_data};
  assign len_bad = (len_d == 16'd0) || ({1'b0, len_d} > MAX_LEN);

  // The byte being accepted in DATA is the final one of the image.
  assign last_byte = ({1'b0, cnt_q} == (len_q - 16'd1));

`ifdef CART_LOADER_CHECKSUM_EN
  assign sum_d = sum_q + rx_data;
  assign in_frame = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
`else
  assign in_frame = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA);
`endif

  // Inter-byte silence has lasted TIMEOUT_CYCLES clocks on this edge.
  assign tmo_hit = in_frame && !rx_valid && (tmo_q == TMO_LAST);

  // Frame FSM with registered BRAM write port and status outputs.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
`ifdef CART_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      wea_q <= 1'b0;

      // Idle counter only runs inside a frame and restarts on every byte.
      if (rx_valid || !in_frame) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (tmo_hit) begin
        state_q <= S_ERR;
        busy_q  <= 1'b0;
        error_q <= 1'b1;
      end else if (rx_valid) begin
        case (state_q)
          S_IDLE, S_DONE, S_ERR: begin
            if (rx_data == SYNC_BYTE) begin
              state_q <= S_LEN_HI;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              error_q <= 1'b0;
              hold_q  <= 1'b1;
            end
          end
          S_LEN_HI: begin
            len_q[15:8] <= rx_data;
            state_q     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_q[7:0] <= rx_data;
            cnt_q      <= '0;
`ifdef CART_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
            if (len_bad) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            wea_q   <= 1'b1;
            addra_q <= cnt_q;
            dina_q  <= rx_data;
            cnt_q   <= cnt_q + 1'b1;
`ifdef CART_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            if (last_byte) begin
              state_q <= S_CHECK;
            end
`else
            if (last_byte) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end
`endif
          end
`ifdef CART_LOADER_CHECKSUM_EN
          S_CHECK: begin
            // Checksum byte is compared only; it never reaches the BRAM.
            if (rx_data == sum_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
`endif
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = hold_q;
  assign dbg_state = state_q;

endmodule
